// File: rtl/cpu_sram_axi_bridge.sv
// rtl/cpu_sram_axi_bridge.sv - sram-like inst/data ports to a single-outstanding simplified AXI master
//
// Ports:
//   clk, reset                          clock; asynchronous active-high reset
//   inst_* / data_*                     sram-like request/response ports (data has priority)
//   arid/araddr/arsize/arvalid/arready  read address channel
//   rid/rdata/rvalid/rready             read data channel (rid not checked)
//   awaddr/awsize/awvalid/awready       write address channel
//   wdata/wstrb/wvalid/wready           write data channel
//   bvalid/bready                       write response channel
module cpu_sram_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t            state, state_next;
    logic              owner_q;        // 1 = data master owns the transaction
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              aw_done, w_done;

    logic              accept;
    logic              sel_data;

    logic unused_rid;
    assign unused_rid = ^rid;

    assign sel_data = data_req;
    assign accept   = (state == IDLE) && (data_req || inst_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner_q <= sel_data;
                wr_q    <= sel_data ? data_wr    : inst_wr;
                size_q  <= sel_data ? data_size  : inst_size;
                addr_q  <= sel_data ? data_addr  : inst_addr;
                wdata_q <= sel_data ? data_wdata : inst_wdata;
            end
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
            if (state == WR_RESP && bvalid) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next   = state;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        case (state)
            IDLE: begin
                // addr_ok is gated by reset so nothing is accepted while held in reset
                if (!reset) begin
                    if (data_req) begin
                        data_addr_ok = 1'b1;
                        state_next   = data_wr ? WR_ADDR : RD_ADDR;
                    end else if (inst_req) begin
                        inst_addr_ok = 1'b1;
                        state_next   = inst_wr ? WR_ADDR : RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_next = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    inst_data_ok = ~owner_q;
                    data_data_ok = owner_q;
                    state_next   = IDLE;
                end
            end
            WR_ADDR: begin
                awvalid = ~aw_done;
                wvalid  = ~w_done;
                // a handshake in this cycle counts as done, so simultaneous readies finish in one cycle
                if ((aw_done || awready) && (w_done || wready)) state_next = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    inst_data_ok = ~owner_q;
                    data_data_ok = owner_q;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    assign arid       = {3'b000, owner_q};
    assign araddr     = addr_q;
    assign arsize     = {1'b0, size_q};
    assign awaddr     = addr_q;
    assign awsize     = {1'b0, size_q};
    assign wdata      = wdata_q;
    assign inst_rdata = rdata;
    assign data_rdata = rdata;

    logic unused_wr;
    assign unused_wr = wr_q;

endmodule

// File: tb/tb_cpu_sram_axi_bridge.sv
// tb/tb_cpu_sram_axi_bridge.sv - directed self-checking bench for cpu_sram_axi_bridge
module tb_cpu_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic [3:0]  arid, rid, wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;

    int n_cmp = 0;
    int n_err = 0;
    int pulses;

    always #5 clk = ~clk;

    cpu_sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance to just after the rising edge; inputs are driven here
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle, still well before the next edge
    task automatic settle();
        #3;
    endtask

    task automatic do_write(input logic [1:0] sz, input logic [31:0] a, input logic [3:0] exp_strb);
        cyc();
        data_req = 1'b1; data_wr = 1'b1; data_size = sz; data_addr = a; data_wdata = a ^ 32'h5555_5555;
        awready = 1'b1; wready = 1'b1;
        settle();
        check("wr_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        cyc();
        data_req = 1'b0;
        settle();
        check("wr_awvalid", {31'd0, awvalid}, 32'd1);
        check("wr_wvalid", {31'd0, wvalid}, 32'd1);
        check("wr_wstrb", {28'd0, wstrb}, {28'd0, exp_strb});
        check("wr_awsize", {29'd0, awsize}, {30'd0, sz});
        check("wr_wdata", wdata, a ^ 32'h5555_5555);
        cyc();
        bvalid = 1'b1;
        settle();
        check("wr_resp_awvalid", {31'd0, awvalid}, 32'd0);
        check("wr_resp_wvalid", {31'd0, wvalid}, 32'd0);
        check("wr_bready", {31'd0, bready}, 32'd1);
        check("wr_data_ok", {31'd0, data_data_ok}, 32'd1);
        cyc();
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        cyc(); cyc();
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_awvalid", {31'd0, awvalid}, 32'd0);
        check("rst_wvalid", {31'd0, wvalid}, 32'd0);
        check("rst_rready", {31'd0, rready}, 32'd0);
        check("rst_bready", {31'd0, bready}, 32'd0);
        reset = 1'b0;

        // single inst read with immediate arready/rvalid
        cyc();
        inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2; arready = 1;
        settle();
        check("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        check("t1_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        cyc();
        inst_req = 0;
        settle();
        check("t1_arvalid", {31'd0, arvalid}, 32'd1);
        check("t1_arid", {28'd0, arid}, 32'd0);
        check("t1_arsize", {29'd0, arsize}, 32'd2);
        check("t1_araddr", araddr, 32'hBFC0_0000);
        check("t1_no_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        cyc();
        rvalid = 1; rdata = 32'h3C1D_0000;
        settle();
        check("t1_rready", {31'd0, rready}, 32'd1);
        check("t1_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
        check("t1_inst_rdata", inst_rdata, 32'h3C1D_0000);
        check("t1_data_data_ok", {31'd0, data_data_ok}, 32'd0);
        cyc();
        rvalid = 0; arready = 0;
        settle();
        check("t1_idle_arvalid", {31'd0, arvalid}, 32'd0);
        check("t1_data_ok_pulse", {31'd0, inst_data_ok}, 32'd0);

        // simultaneous requests: data wins, inst follows
        inst_req = 1; inst_addr = 32'hBFC0_0004;
        data_req = 1; data_wr = 0; data_addr = 32'h8000_1000; data_size = 2'd2;
        settle();
        check("t2_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        check("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        cyc();
        data_req = 0; arready = 1;
        settle();
        check("t2_arid", {28'd0, arid}, 32'd1);
        check("t2_araddr", araddr, 32'h8000_1000);
        check("t2_inst_blocked", {31'd0, inst_addr_ok}, 32'd0);
        cyc();
        rvalid = 1; rdata = 32'h1234_5678;
        settle();
        check("t2_data_data_ok", {31'd0, data_data_ok}, 32'd1);
        check("t2_data_rdata", data_rdata, 32'h1234_5678);
        check("t2_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
        cyc();
        rvalid = 0;
        settle();
        check("t2_inst_accept", {31'd0, inst_addr_ok}, 32'd1);
        cyc();
        inst_req = 0;
        settle();
        check("t2_inst_arid", {28'd0, arid}, 32'd0);
        check("t2_inst_araddr", araddr, 32'hBFC0_0004);
        cyc();
        rvalid = 1; rdata = 32'h0000_0042;
        settle();
        check("t2_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
        cyc();
        rvalid = 0; arready = 0;

        // data byte write with awready delayed two cycles
        data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h8000_0003; data_wdata = 32'hAAAA_AAAA;
        wready = 1;
        settle();
        check("t3_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        cyc();
        data_req = 0;
        settle();
        check("t3_wstrb", {28'd0, wstrb}, 32'h8);
        check("t3_awaddr", awaddr, 32'h8000_0003);
        check("t3_wdata", wdata, 32'hAAAA_AAAA);
        check("t3_awvalid_c1", {31'd0, awvalid}, 32'd1);
        check("t3_wvalid_c1", {31'd0, wvalid}, 32'd1);
        cyc();
        wready = 0;
        settle();
        check("t3_awvalid_c2", {31'd0, awvalid}, 32'd1);
        check("t3_wvalid_c2", {31'd0, wvalid}, 32'd0);
        cyc();
        awready = 1;
        settle();
        check("t3_awvalid_c3", {31'd0, awvalid}, 32'd1);
        check("t3_wvalid_c3", {31'd0, wvalid}, 32'd0);
        cyc();
        awready = 0;
        settle();
        check("t3_awvalid_c4", {31'd0, awvalid}, 32'd0);
        check("t3_bready", {31'd0, bready}, 32'd1);
        check("t3_no_ok_early", {31'd0, data_data_ok}, 32'd0);
        cyc();
        bvalid = 1;
        settle();
        check("t3_data_ok", {31'd0, data_data_ok}, 32'd1);
        cyc();
        bvalid = 0;

        // wstrb table with simultaneous awready/wready
        do_write(2'd1, 32'h8000_0002, 4'b1100);
        do_write(2'd1, 32'h8000_0000, 4'b0011);
        do_write(2'd2, 32'h8000_0010, 4'b1111);
        do_write(2'd0, 32'h8000_0001, 4'b0010);
        do_write(2'd3, 32'h8000_0021, 4'b1111);

        // stalled read: arready low 5 cycles, rvalid 4 cycles late, inst_req pending throughout
        cyc();
        inst_req = 1; inst_addr = 32'hBFC0_0100;
        data_req = 1; data_wr = 0; data_size = 2'd1; data_addr = 32'h8000_2000;
        settle();
        check("t5_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        pulses = 0;
        cyc();
        data_req = 0;
        for (int i = 0; i < 12; i++) begin
            arready = (i == 5);
            rvalid  = (i == 10);
            rdata   = 32'hCAFE_0000 + i;
            if (i == 11) inst_req = 0;
            settle();
            if (i <= 5) begin
                check("t5_arvalid_held", {31'd0, arvalid}, 32'd1);
                check("t5_araddr_stable", araddr, 32'h8000_2000);
                check("t5_arsize", {29'd0, arsize}, 32'd1);
            end
            if (i < 11) check("t5_no_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
            if (i == 10) check("t5_rdata", data_rdata, 32'hCAFE_000A);
            if (data_data_ok) pulses++;
            cyc();
        end
        check("t5_one_pulse", pulses, 32'd1);
        arready = 0; rvalid = 0; inst_req = 0;

        // reset during WR_RESP
        do_write(2'd2, 32'h8000_0040, 4'b1111);
        // do_write ends in IDLE; start another write and stop in WR_RESP
        data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h8000_0080; data_wdata = 32'h1;
        awready = 1; wready = 1;
        cyc();
        data_req = 0;
        cyc();
        awready = 0; wready = 0;
        settle();
        check("t6_bready_before", {31'd0, bready}, 32'd1);
        reset = 1;
        #1;
        check("t6_bready", {31'd0, bready}, 32'd0);
        check("t6_valids", {27'd0, arvalid, awvalid, wvalid, rready, data_data_ok}, 32'd0);
        cyc();
        reset = 0;
        bvalid = 1;
        settle();
        check("t6_no_data_ok", {31'd0, data_data_ok}, 32'd0);
        check("t6_bready_after", {31'd0, bready}, 32'd0);
        cyc();
        bvalid = 0;
        data_req = 1; data_wr = 0; data_addr = 32'h8000_0100; arready = 1;
        settle();
        check("t6_idle_accept", {31'd0, data_addr_ok}, 32'd1);
        cyc();
        data_req = 0;
        cyc();
        rvalid = 1; rdata = 32'h7777_7777;
        settle();
        check("t6_read_after_reset", {31'd0, data_data_ok}, 32'd1);
        cyc();
        rvalid = 0; arready = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_sram_axi_bridge.md
Name: cpu_sram_axi_bridge

Overview:
- Sits directly downstream of the CPU top's inst/data memory ports.
- Converts the two sram-like request/response interfaces (inst, data) into one simplified AXI master port.
- Single outstanding transaction at a time; data requests have priority over inst requests.
- Fixed AXI fields (len=0, burst=INCR, lock, cache, prot, wid, awid) are tied off at the SoC wrapper and are not ports of this block.

Parameters:
- ADDR_W, 32, address width of both sides
- DATA_W, 32, data width (only 32 supported; wstrb is 4 bits)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears FSM and all valids
- inst_req / inst_wr  in  1 / 1  inst request valid; write flag (always 0 from IF, honoured if set)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr / inst_wdata  in  32 / 32  request address / write data
- inst_addr_ok / inst_data_ok  out  1 / 1  request accepted / response valid (1-cycle pulses)
- inst_rdata  out  32  read data, valid with inst_data_ok
- data_req, data_wr, data_size, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata  same as inst_*, for the data master
- arid / araddr / arsize / arvalid  out  4 / 32 / 3 / 1  read address channel; arid=0 inst, 1 data; arsize={1'b0,size}
- arready  in  1
- rid / rdata / rvalid  in  4 / 32 / 1  read data channel
- rready  out  1
- awaddr / awsize / awvalid  out  32 / 3 / 1  write address channel
- awready  in  1
- wdata / wstrb / wvalid  out  32 / 4 / 1  write data channel
- wready  in  1
- bvalid  in  1
- bready  out  1

Behaviour:
- Reset (async): state=IDLE; arvalid, awvalid, wvalid, rready, bready, *_addr_ok, *_data_ok = 0; latched request regs = 0.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE, master select: data_req=1 selects data, else inst_req=1 selects inst.
  - Selected master's addr_ok=1 combinationally in the same cycle; the other master's addr_ok=0.
  - On accept, latch owner, wr, size, addr, wdata.
  - Next state is RD_ADDR if wr=0, else WR_ADDR.
- RD_ADDR: arvalid=1 with the latched addr/size/id. On arready, go to RD_DATA. No addr_ok to either master outside IDLE.
- RD_DATA: rready=1.
  - On rvalid: owner's data_ok=1 (combinational) and owner's rdata=rdata; return to IDLE.
  - The new request is sampled in IDLE the following cycle, so there is no same-cycle accept.
  - rid is not checked.
- WR_ADDR: awvalid and wvalid start together.
  - Each drops independently after its own handshake, tracked by aw_done/w_done flags.
  - Go to WR_RESP once both are done; a same-cycle awready+wready goes there in one cycle.
- WR_RESP: bready=1. On bvalid: owner's data_ok=1, clear the flags, go to IDLE.
- wstrb derivation:
  - size0: 4'b0001<<addr[1:0]
  - size1: addr[1] ? 4'b1100 : 4'b0011
  - size2: 4'b1111
  - size3: treated as size2
- wdata is passed unmodified; the CPU already replicates byte/half lanes.
- Latency: minimum read is 3 cycles from req to data_ok when arready and rvalid respond immediately (IDLE→RD_ADDR→RD_DATA). Minimum write is 3 cycles.
- No other output change is permitted while AXI valid signals are held. araddr/awaddr/wdata/wstrb are stable from valid assertion until handshake.
- Only one transaction is ever in flight, so there is no read-after-write hazard.
- Non-owner data_ok is always 0. rdata outputs to the non-owner may mirror the bus but must not be qualified.
- Reset asserted mid-transaction: the FSM aborts to IDLE immediately and valids drop. Any pending AXI response after reset is ignored (rready/bready=0).

Test Plan:
- Single inst read, addr 0xBFC00000, arready=1, rvalid=1 next cycle with rdata=0x3C1D0000:
  - inst_addr_ok in cycle 0; arvalid cycle 1 with arid=0, arsize=2.
  - inst_data_ok=1 with inst_rdata=0x3C1D0000 in cycle 2.
- Simultaneous inst_req and data_req (read, addr 0x80001000):
  - Only data_addr_ok=1; arid=1 issued.
  - After data_data_ok, inst is accepted in the next IDLE cycle.
- Data byte write, size=0, addr 0x80000003, wdata=0xAAAAAAAA, awready delayed 2 cycles, wready immediate:
  - wstrb=4'b1000; wvalid drops after 1 cycle; awvalid held 3 cycles.
  - data_data_ok on bvalid.
- Half write at addr 0x80000002 → wstrb=4'b1100; word write → 4'b1111; awready and wready in the same cycle → WR_RESP next cycle.
- Read with arready low 5 cycles and rvalid delayed 4 cycles:
  - araddr/arvalid stable throughout; no addr_ok to either master meanwhile.
  - Exactly one data_ok pulse.
- Assert reset during WR_RESP:
  - All valids/readies are 0 the same cycle; state=IDLE.
  - A subsequent bvalid produces no data_ok.
